// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: master ids and AHB transfer encodings for the arbiter.
package ahb_arb_pkg;
    typedef enum logic [1:0] {
        MST_DEFAULT = 2'd0,
        MST_M1      = 2'd1,
        MST_M2      = 2'd2
    } mst_e;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_WORD = 3'b010;
endpackage

// File: rtl/ahb_grant_select.sv
// ahb_grant_select: combinational next-grant choice; M2 over M1, or round-robin
// with a hold limit when ARB_ROUND_ROBIN_EN is defined.
module ahb_grant_select
    import ahb_arb_pkg::*;
`ifdef ARB_ROUND_ROBIN_EN
#(
    parameter int HOLD_MAX = 16
)
`endif
(
    input  logic i_req1,
    input  logic i_req2,
`ifdef ARB_ROUND_ROBIN_EN
    input  mst_e i_grant,
    input  mst_e i_last,
    input  logic [$clog2(HOLD_MAX+1)-1:0] i_hold_cnt,
`endif
    output mst_e o_next
);
`ifdef ARB_ROUND_ROBIN_EN
    localparam int CW = $clog2(HOLD_MAX + 1);
    mst_e w_tie;
    // A parked bus hands a tie to whoever did not own last; an owner keeps it until its quota runs out.
    assign w_tie = (i_grant == MST_DEFAULT) ? ((i_last == MST_M1) ? MST_M2 : MST_M1)
                 : (i_hold_cnt >= CW'(HOLD_MAX - 1)) ? ((i_grant == MST_M1) ? MST_M2 : MST_M1)
                 : i_grant;
    assign o_next = (i_req1 && i_req2) ? w_tie : i_req2 ? MST_M2 : i_req1 ? MST_M1 : MST_DEFAULT;
`else
    assign o_next = i_req2 ? MST_M2 : i_req1 ? MST_M1 : MST_DEFAULT;
`endif
endmodule

// File: rtl/macro.sv
// macro.sv: bus-width defines shared by the AHB arbiter and its users.
`ifndef AHB_MACRO_SV
`define AHB_MACRO_SV
`define AHB_ADDR_BITS 32
`define AHB_DATA_BITS 32
`endif

// File: rtl/ahb_arbiter_mux.sv
// ahb_arbiter_mux: two-master AHB arbiter and bus mux, parking on an IDLE default master.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration with a HOLD_MAX quota.
`include "macro.sv"
module ahb_arbiter_mux
    import ahb_arb_pkg::*;
#(
    parameter int ADDR_W = `AHB_ADDR_BITS,
    parameter int DATA_W = `AHB_DATA_BITS
`ifdef ARB_ROUND_ROBIN_EN
    , parameter int HOLD_MAX = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HBUSREQ_M1,
    input  logic              HBUSREQ_M2,
    input  logic              HLOCK_M1,
    input  logic              HLOCK_M2,
    input  logic [ADDR_W-1:0] HADDR_M1,
    input  logic [ADDR_W-1:0] HADDR_M2,
    input  logic [1:0]        HTRANS_M1,
    input  logic [1:0]        HTRANS_M2,
    input  logic              HWRITE_M1,
    input  logic              HWRITE_M2,
    input  logic [2:0]        HSIZE_M1,
    input  logic [2:0]        HSIZE_M2,
    input  logic [DATA_W-1:0] HWDATA_M1,
    input  logic [DATA_W-1:0] HWDATA_M2,
    input  logic              HREADY,
    output logic              HGRANT_M1,
    output logic              HGRANT_M2,
    output logic [1:0]        HMASTER,
    output logic              HMASTLOCK,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA
);
    mst_e r_grant, r_hmaster, r_hmaster_d, w_next, w_grant_d;
    logic r_mastlock, w_lock_g, w_hold;

    assign w_lock_g  = (r_grant == MST_M1 && HLOCK_M1) || (r_grant == MST_M2 && HLOCK_M2);
    // Locked owners and bursts in flight (BUSY/SEQ on the bus) keep the grant.
    assign w_hold    = w_lock_g || HTRANS == BUSY || HTRANS == SEQ;
    assign w_grant_d = w_hold ? r_grant : w_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant     <= MST_DEFAULT;
            r_hmaster   <= MST_DEFAULT;
            r_hmaster_d <= MST_DEFAULT;
            r_mastlock  <= 1'b0;
        end else if (HREADY) begin
            r_grant     <= w_grant_d;
            r_hmaster   <= r_grant;
            r_hmaster_d <= r_hmaster;
            r_mastlock  <= w_lock_g;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    localparam int CW = $clog2(HOLD_MAX + 1);
    logic [CW-1:0] r_hold_cnt;
    mst_e          r_last;
    logic          w_other_req;

    assign w_other_req = (r_grant == MST_M1 && HBUSREQ_M2) || (r_grant == MST_M2 && HBUSREQ_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
            r_last     <= MST_M1;
        end else if (HREADY) begin
            r_hold_cnt <= (w_grant_d != r_grant) ? '0
                        : (w_other_req && r_hold_cnt != CW'(HOLD_MAX)) ? r_hold_cnt + 1'b1
                        : r_hold_cnt;
            if (r_grant != MST_DEFAULT) r_last <= r_grant;
        end
    end

    ahb_grant_select #(.HOLD_MAX(HOLD_MAX)) u_sel (
        .i_req1     (HBUSREQ_M1),
        .i_req2     (HBUSREQ_M2),
        .i_grant    (r_grant),
        .i_last     (r_last),
        .i_hold_cnt (r_hold_cnt),
        .o_next     (w_next)
    );
`else
    ahb_grant_select u_sel (
        .i_req1 (HBUSREQ_M1),
        .i_req2 (HBUSREQ_M2),
        .o_next (w_next)
    );
`endif

    assign HGRANT_M1 = r_grant == MST_M1;
    assign HGRANT_M2 = r_grant == MST_M2;
    assign HMASTER   = r_hmaster;
    assign HMASTLOCK = r_mastlock;
    assign HADDR     = r_hmaster == MST_M1 ? HADDR_M1  : r_hmaster == MST_M2 ? HADDR_M2  : '0;
    assign HTRANS    = r_hmaster == MST_M1 ? HTRANS_M1 : r_hmaster == MST_M2 ? HTRANS_M2 : IDLE;
    assign HWRITE    = r_hmaster == MST_M1 ? HWRITE_M1 : r_hmaster == MST_M2 ? HWRITE_M2 : 1'b0;
    assign HSIZE     = r_hmaster == MST_M1 ? HSIZE_M1  : r_hmaster == MST_M2 ? HSIZE_M2  : 3'b000;
    assign HWDATA    = r_hmaster_d == MST_M1 ? HWDATA_M1 : r_hmaster_d == MST_M2 ? HWDATA_M2 : '0;
endmodule

// File: tb/tb_ahb_arbiter_mux.sv
// tb_ahb_arbiter_mux: directed scenarios for the default fixed-priority arbiter build.
module tb_ahb_arbiter_mux;
    import ahb_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        HBUSREQ_M1, HBUSREQ_M2, HLOCK_M1, HLOCK_M2;
    logic [31:0] HADDR_M1, HADDR_M2, HWDATA_M1, HWDATA_M2;
    logic [1:0]  HTRANS_M1, HTRANS_M2;
    logic        HWRITE_M1, HWRITE_M2;
    logic [2:0]  HSIZE_M1, HSIZE_M2;
    logic        HREADY;
    logic        HGRANT_M1, HGRANT_M2, HMASTLOCK, HWRITE;
    logic [1:0]  HMASTER, HTRANS;
    logic [31:0] HADDR, HWDATA;
    logic [2:0]  HSIZE;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ahb_arbiter_mux dut (
        .clk(clk), .rst(rst),
        .HBUSREQ_M1(HBUSREQ_M1), .HBUSREQ_M2(HBUSREQ_M2),
        .HLOCK_M1(HLOCK_M1), .HLOCK_M2(HLOCK_M2),
        .HADDR_M1(HADDR_M1), .HADDR_M2(HADDR_M2),
        .HTRANS_M1(HTRANS_M1), .HTRANS_M2(HTRANS_M2),
        .HWRITE_M1(HWRITE_M1), .HWRITE_M2(HWRITE_M2),
        .HSIZE_M1(HSIZE_M1), .HSIZE_M2(HSIZE_M2),
        .HWDATA_M1(HWDATA_M1), .HWDATA_M2(HWDATA_M2),
        .HREADY(HREADY),
        .HGRANT_M1(HGRANT_M1), .HGRANT_M2(HGRANT_M2),
        .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HWDATA(HWDATA)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        HBUSREQ_M1 = 0; HBUSREQ_M2 = 0; HLOCK_M1 = 0; HLOCK_M2 = 0;
        HADDR_M1 = '0; HADDR_M2 = '0; HWDATA_M1 = '0; HWDATA_M2 = '0;
        HTRANS_M1 = IDLE; HTRANS_M2 = IDLE; HWRITE_M1 = 0; HWRITE_M2 = 0;
        HSIZE_M1 = '0; HSIZE_M2 = '0; HREADY = 1;
    endtask

    task automatic park();
        clear_inputs();
        rst = 0;
        repeat (3) cyc();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; HBUSREQ_M1 = 1; HTRANS_M1 = NONSEQ; HADDR_M1 = 32'h44;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++; if (HGRANT_M1 !== 1'b0) begin errors++; $display("FAIL reset_gnt1 cyc%0d got=%b exp=0", i, HGRANT_M1); end
            checks++; if (HGRANT_M2 !== 1'b0) begin errors++; $display("FAIL reset_gnt2 cyc%0d got=%b exp=0", i, HGRANT_M2); end
            checks++; if (HMASTER !== 2'd0) begin errors++; $display("FAIL reset_hmaster cyc%0d got=%0d exp=0", i, HMASTER); end
            checks++; if (HTRANS !== IDLE) begin errors++; $display("FAIL reset_htrans cyc%0d got=%0d exp=0", i, HTRANS); end
            checks++; if (HADDR !== 32'h0) begin errors++; $display("FAIL reset_haddr cyc%0d got=%h exp=0", i, HADDR); end
            checks++; if (HMASTLOCK !== 1'b0) begin errors++; $display("FAIL reset_lock cyc%0d got=%b exp=0", i, HMASTLOCK); end
        end
        rst = 0;
        cyc();
        checks++; if (HGRANT_M1 !== 1'b1) begin errors++; $display("FAIL reset_release_gnt1 got=%b exp=1", HGRANT_M1); end
        checks++; if (HMASTER !== 2'd0) begin errors++; $display("FAIL reset_release_hmaster got=%0d exp=0", HMASTER); end
    endtask

    task automatic test_single_read();
        park();
        HBUSREQ_M1 = 1; HTRANS_M1 = NONSEQ; HADDR_M1 = 32'h0000_0100; HSIZE_M1 = HSIZE_WORD;
        cyc();
        checks++; if (HGRANT_M1 !== 1'b1) begin errors++; $display("FAIL single_gnt got=%b exp=1", HGRANT_M1); end
        checks++; if (HTRANS !== IDLE) begin errors++; $display("FAIL single_pre_idle got=%0d exp=0", HTRANS); end
        cyc();
        checks++; if (HMASTER !== 2'd1) begin errors++; $display("FAIL single_hmaster got=%0d exp=1", HMASTER); end
        checks++; if (HADDR !== 32'h100) begin errors++; $display("FAIL single_haddr got=%h exp=00000100", HADDR); end
        checks++; if (HTRANS !== NONSEQ) begin errors++; $display("FAIL single_htrans got=%0d exp=2", HTRANS); end
        checks++; if (HSIZE !== HSIZE_WORD) begin errors++; $display("FAIL single_hsize got=%0d exp=2", HSIZE); end
        checks++; if (HWRITE !== 1'b0) begin errors++; $display("FAIL single_hwrite got=%b exp=0", HWRITE); end
        HBUSREQ_M1 = 0; HTRANS_M1 = IDLE;
        cyc();
        checks++; if (HGRANT_M1 !== 1'b0) begin errors++; $display("FAIL single_release got=%b exp=0", HGRANT_M1); end
        cyc();
        checks++; if (HMASTER !== 2'd0) begin errors++; $display("FAIL single_park_hmaster got=%0d exp=0", HMASTER); end
        checks++; if (HTRANS !== IDLE) begin errors++; $display("FAIL single_park_htrans got=%0d exp=0", HTRANS); end
        checks++; if (HADDR !== 32'h0) begin errors++; $display("FAIL single_park_haddr got=%h exp=0", HADDR); end
    endtask

    task automatic test_contention();
        park();
        HBUSREQ_M1 = 1; HBUSREQ_M2 = 1; HTRANS_M1 = NONSEQ; HTRANS_M2 = NONSEQ;
        HADDR_M1 = 32'h1000; HADDR_M2 = 32'h2000;
        cyc();
        checks++; if (HGRANT_M2 !== 1'b1) begin errors++; $display("FAIL cont_gnt2 got=%b exp=1", HGRANT_M2); end
        checks++; if (HGRANT_M1 !== 1'b0) begin errors++; $display("FAIL cont_gnt1 got=%b exp=0", HGRANT_M1); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++; if (HGRANT_M2 !== 1'b1 || HGRANT_M1 !== 1'b0) begin errors++; $display("FAIL cont_hold cyc%0d got=%b%b exp=10", i, HGRANT_M2, HGRANT_M1); end
            checks++; if (HADDR !== 32'h2000) begin errors++; $display("FAIL cont_haddr cyc%0d got=%h exp=00002000", i, HADDR); end
        end
        HBUSREQ_M2 = 0; HTRANS_M2 = IDLE;
        cyc();
        checks++; if (HGRANT_M1 !== 1'b1) begin errors++; $display("FAIL cont_handover got=%b exp=1", HGRANT_M1); end
        cyc();
        checks++; if (HMASTER !== 2'd1) begin errors++; $display("FAIL cont_hmaster got=%0d exp=1", HMASTER); end
    endtask

    task automatic test_lock();
        park();
        HBUSREQ_M1 = 1; HLOCK_M1 = 1; HTRANS_M1 = NONSEQ;
        cyc();
        checks++; if (HGRANT_M1 !== 1'b1) begin errors++; $display("FAIL lock_gnt1 got=%b exp=1", HGRANT_M1); end
        HBUSREQ_M2 = 1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++; if (HGRANT_M2 !== 1'b0) begin errors++; $display("FAIL lock_gnt2 cyc%0d got=%b exp=0", i, HGRANT_M2); end
            checks++; if (HMASTLOCK !== 1'b1) begin errors++; $display("FAIL lock_mastlock cyc%0d got=%b exp=1", i, HMASTLOCK); end
        end
        HLOCK_M1 = 0;
        cyc();
        checks++; if (HGRANT_M2 !== 1'b1) begin errors++; $display("FAIL unlock_gnt2 got=%b exp=1", HGRANT_M2); end
        checks++; if (HMASTLOCK !== 1'b0) begin errors++; $display("FAIL unlock_mastlock got=%b exp=0", HMASTLOCK); end
    endtask

    task automatic test_wait_states();
        park();
        HBUSREQ_M2 = 1; HWRITE_M2 = 1; HTRANS_M2 = NONSEQ; HADDR_M2 = 32'h200;
        HSIZE_M2 = HSIZE_WORD; HWDATA_M2 = 32'hDEAD_BEEF;
        cyc();
        cyc();
        checks++; if (HMASTER !== 2'd2) begin errors++; $display("FAIL wait_addr_hmaster got=%0d exp=2", HMASTER); end
        checks++; if (HWRITE !== 1'b1) begin errors++; $display("FAIL wait_hwrite got=%b exp=1", HWRITE); end
        HBUSREQ_M1 = 1; HTRANS_M1 = NONSEQ;
        cyc();
        checks++; if (HWDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wait_data_phase got=%h exp=deadbeef", HWDATA); end
        HREADY = 0; HBUSREQ_M2 = 0; HTRANS_M2 = IDLE;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (HWDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wait_hwdata cyc%0d got=%h exp=deadbeef", i, HWDATA); end
            checks++; if (HMASTER !== 2'd2) begin errors++; $display("FAIL wait_hmaster cyc%0d got=%0d exp=2", i, HMASTER); end
            checks++; if (HGRANT_M2 !== 1'b1 || HGRANT_M1 !== 1'b0) begin errors++; $display("FAIL wait_grant cyc%0d got=%b%b exp=10", i, HGRANT_M2, HGRANT_M1); end
        end
        HREADY = 1;
        cyc();
        checks++; if (HGRANT_M1 !== 1'b1) begin errors++; $display("FAIL wait_release_gnt1 got=%b exp=1", HGRANT_M1); end
    endtask

    task automatic test_seq_hold();
        park();
        HBUSREQ_M1 = 1; HTRANS_M1 = NONSEQ; HADDR_M1 = 32'h300;
        cyc();
        cyc();
        checks++; if (HMASTER !== 2'd1) begin errors++; $display("FAIL seq_hmaster got=%0d exp=1", HMASTER); end
        HTRANS_M1 = SEQ; HBUSREQ_M2 = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) HTRANS_M1 = BUSY;
            cyc();
            checks++; if (HGRANT_M1 !== 1'b1 || HGRANT_M2 !== 1'b0) begin errors++; $display("FAIL seq_hold cyc%0d got=%b%b exp=10", i, HGRANT_M1, HGRANT_M2); end
        end
        HTRANS_M1 = NONSEQ;
        cyc();
        checks++; if (HGRANT_M2 !== 1'b1 || HGRANT_M1 !== 1'b0) begin errors++; $display("FAIL seq_release got=%b%b exp=10", HGRANT_M2, HGRANT_M1); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_lock();
        test_wait_states();
        test_seq_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
